ser_add: RTL and testbench

Multi-cycle, digit-serial adder with a start/done handshake. It is the parametrised successor to the single-bit full adder. A WIDTH-bit addition is carried out DIGIT bits per clock through one DIGIT-bit adder slice and a registered carry, which trades latency for area. It sits beside the combinational adders and serves datapaths where a full-width carry chain costs too much area or timing.

---
 rtl/ser_add.sv | 118 +++++++++++
 tb/tb_ser_add.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ser_add.sv
// ser_add: digit-serial adder, DIGIT bits per clock, start/done handshake.
// Optional subtract mode (sub port) is built when SER_ADD_SUB_EN is defined.
module ser_add #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SER_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, acc, acc_nx;
  logic [CW-1:0]    cnt;
  logic             c;
  logic             accept, last, cmsb;
  logic             ld_c;
  logic [DIGIT-1:0] ad, bd;
  logic [DIGIT:0]   dsum;

`ifdef SER_ADD_SUB_EN
  logic sub_r;
  assign ld_c = sub ? 1'b1 : cin;
  assign bd   = sub_r ? ~b_sh[DIGIT-1:0] : b_sh[DIGIT-1:0];
`else
  assign ld_c = cin;
  assign bd   = b_sh[DIGIT-1:0];
`endif

  assign ad     = a_sh[DIGIT-1:0];
  assign dsum   = {1'b0, ad} + {1'b0, bd} + {{DIGIT{1'b0}}, c};
  // carry into the digit MSB recovered from its sum bit
  assign cmsb   = ad[DIGIT-1] ^ bd[DIGIT-1] ^ dsum[DIGIT-1];
  assign last   = (cnt == CW'(N - 1));
  assign accept = start && (state == IDLE || state == DONE);
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  always_comb begin
    acc_nx = acc >> DIGIT;
    acc_nx[WIDTH-1 -: DIGIT] = dsum[DIGIT-1:0];
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      acc  <= '0;
      cnt  <= '0;
      c    <= 1'b0;
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
`ifdef SER_ADD_SUB_EN
      sub_r <= 1'b0;
`endif
    end else if (accept) begin
      a_sh <= a;
      b_sh <= b;
      c    <= ld_c;
      cnt  <= '0;
`ifdef SER_ADD_SUB_EN
      sub_r <= sub;
`endif
    end else if (state == RUN) begin
      a_sh <= a_sh >> DIGIT;
      b_sh <= b_sh >> DIGIT;
      acc  <= acc_nx;
      c    <= dsum[DIGIT];
      cnt  <= cnt + CW'(1);
      // visible outputs move only on the final digit
      if (last) begin
        sum  <= acc_nx;
        cout <= dsum[DIGIT];
        ovf  <= cmsb ^ dsum[DIGIT];
      end
    end
  end

endmodule

// File: tb/tb_ser_add.sv
// tb_ser_add: scoreboard bench for ser_add (8/1 and 16/4 instances).
// Subtract cases run only when SER_ADD_SUB_EN is defined.
module tb_ser_add;

  typedef struct {
    logic [15:0] s;
    logic        co;
    logic        ov;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start8, cin8, start16, cin16;
  logic [7:0]  a8, b8, sum8, last8;
  logic [15:0] a16, b16, sum16;
  logic        busy8, done8, cout8, ovf8;
  logic        busy16, done16, cout16, ovf16;
`ifdef SER_ADD_SUB_EN
  logic        sub8;
`endif
  int          checks = 0;
  int          fails = 0;
  int          n;
  exp_t        q8[$];
  exp_t        q16[$];

  always #5 clk = ~clk;

  ser_add #(.WIDTH(8), .DIGIT(1)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8),
    .a(a8), .b(b8), .cin(cin8),
`ifdef SER_ADD_SUB_EN
    .sub(sub8),
`endif
    .busy(busy8), .done(done8), .sum(sum8),
    .cout(cout8), .ovf(ovf8)
  );

  ser_add #(.WIDTH(16), .DIGIT(4)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start16),
    .a(a16), .b(b16), .cin(cin16),
`ifdef SER_ADD_SUB_EN
    .sub(1'b0),
`endif
    .busy(busy16), .done(done16), .sum(sum16),
    .cout(cout16), .ovf(ovf16)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int w,
                                 input logic [15:0] a,
                                 input logic [15:0] b,
                                 input logic ci,
                                 input logic sb);
    logic [16:0] m, aa, bb, f;
    exp_t e;
    m  = (17'd1 << w) - 17'd1;
    aa = {1'b0, a} & m;
    bb = (sb ? ~{1'b0, b} : {1'b0, b}) & m;
    f  = aa + bb + {16'd0, (sb ? 1'b1 : ci)};
    e.s  = f[15:0] & m[15:0];
    e.co = f[w];
    e.ov = (aa[w-1] ^ bb[w-1] ^ f[w-1]) ^ f[w];
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("busy_done8", {31'd0, busy8 & done8}, 0);
      if (done8) begin
        if (q8.size() == 0) chk("sb8_empty", 1, 0);
        else begin
          e = q8.pop_front();
          chk("sum8", {24'd0, sum8}, {16'd0, e.s});
          chk("cout8", {31'd0, cout8}, {31'd0, e.co});
          chk("ovf8", {31'd0, ovf8}, {31'd0, e.ov});
          last8 = e.s[7:0];
        end
      end
      if (done16) begin
        if (q16.size() == 0) chk("sb16_empty", 1, 0);
        else begin
          e = q16.pop_front();
          chk("sum16", {16'd0, sum16}, {16'd0, e.s});
          chk("cout16", {31'd0, cout16}, {31'd0, e.co});
          chk("ovf16", {31'd0, ovf16}, {31'd0, e.ov});
        end
      end
    end
  end

  task automatic drive8(input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic sb);
    logic eff;
    eff = 1'b0;
`ifdef SER_ADD_SUB_EN
    eff  = sb;
    sub8 = sb;
`endif
    if (sb && !eff) eff = 1'b0;
    start8 = 1'b1;
    a8 = a;
    b8 = b;
    cin8 = ci;
    q8.push_back(model(8, {8'd0, a}, {8'd0, b}, ci, eff));
  endtask

  task automatic go8(input logic [7:0] a, input logic [7:0] b,
                     input logic ci, input logic sb);
    @(negedge clk);
    drive8(a, b, ci, sb);
    @(negedge clk);
    start8 = 1'b0;
    chk("busy8_rise", {31'd0, busy8}, 1);
  endtask

  task automatic wait8(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done8 && cyc < 40);
    if (!done8) chk("timeout8", 0, 1);
  endtask

  task automatic go16(input logic [15:0] a, input logic [15:0] b,
                      input logic ci);
    @(negedge clk);
    start16 = 1'b1;
    a16 = a;
    b16 = b;
    cin16 = ci;
    q16.push_back(model(16, a, b, ci, 1'b0));
    @(negedge clk);
    start16 = 1'b0;
  endtask

  task automatic wait16(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done16 && cyc < 40);
    if (!done16) chk("timeout16", 0, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
`ifdef SER_ADD_SUB_EN
    sub8 = 1'b0;
`endif
    last8 = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy8}, 0);
    chk("rst_done", {31'd0, done8}, 0);
    chk("rst_sum", {24'd0, sum8}, 0);
    chk("rst_cout", {31'd0, cout8}, 0);
    chk("rst_ovf", {31'd0, ovf8}, 0);
    rst_n = 1'b1;

    go8(8'hFF, 8'h01, 1'b0, 1'b0);
    wait8(n);
    chk("lat8", n, 8);
    go8(8'h7F, 8'h01, 1'b0, 1'b0);
    wait8(n);
    go8(8'h80, 8'h80, 1'b1, 1'b0);
    wait8(n);
    @(negedge clk);
    chk("done8_width", {31'd0, done8}, 0);
    repeat (3) @(negedge clk);
    chk("idle_hold8", {24'd0, sum8}, 32'h01);

`ifdef SER_ADD_SUB_EN
    go8(8'h05, 8'h07, 1'b1, 1'b1);
    wait8(n);
    go8(8'h07, 8'h05, 1'b0, 1'b1);
    wait8(n);
`endif

    // start pulsed mid-run must be ignored
    go8(8'h10, 8'h20, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    chk("run_hold8", {24'd0, sum8}, {24'd0, last8});
    @(negedge clk);
    start8 = 1'b0;
    wait8(n);

    // start held through DONE: back-to-back
    @(negedge clk);
    drive8(8'h01, 8'h02, 1'b0, 1'b0);
    @(negedge clk);
    wait8(n);
    drive8(8'h03, 8'h04, 1'b1, 1'b0);
    @(negedge clk);
    start8 = 1'b0;
    chk("b2b_done", {31'd0, done8}, 0);
    chk("b2b_busy", {31'd0, busy8}, 1);
    wait8(n);
    chk("b2b_lat", n, 8);
    @(negedge clk);
    chk("b2b_width", {31'd0, done8}, 0);

    // reset in RUN cycle 4
    go8(8'h55, 8'h11, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy8}, 0);
    chk("abort_done", {31'd0, done8}, 0);
    chk("abort_sum", {24'd0, sum8}, 0);
    chk("abort_cout", {31'd0, cout8}, 0);
    chk("abort_ovf", {31'd0, ovf8}, 0);
    q8.delete();
    @(negedge clk);
    rst_n = 1'b1;
    go8(8'h12, 8'h34, 1'b0, 1'b0);
    wait8(n);
    chk("post_rst_sum", {24'd0, sum8}, 32'h46);

    go16(16'hFFFF, 16'h0001, 1'b0);
    wait16(n);
    chk("lat16", n, 4);
    for (int i = 0; i < 8; i++) begin
      go16(16'($urandom), 16'($urandom), 1'($urandom));
      wait16(n);
    end
    for (int i = 0; i < 6; i++) begin
      go8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
      wait8(n);
    end

    repeat (2) @(negedge clk);
    chk("q8_left", q8.size(), 0);
    chk("q16_left", q16.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
